// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode constants, decode FSM state type and the
// two-word opcode predicate used by the decode stage.
package decode_pkg;

  localparam int unsigned OPW = 5;

  // Two-word opcodes: the second fetched word becomes the immediate
  localparam logic [OPW-1:0] OP_LDM  = 5'b10100;
  localparam logic [OPW-1:0] OP_IADD = 5'b10101;
  localparam logic [OPW-1:0] OP_LDD  = 5'b10110;
  localparam logic [OPW-1:0] OP_STD  = 5'b10111;

  // Interrupt-entry micro-ops injected by the decode stage
  localparam logic [OPW-1:0] OP_PUSHPCH = 5'b11000;
  localparam logic [OPW-1:0] OP_PUSHPCL = 5'b11001;
  localparam logic [OPW-1:0] OP_PUSHCCR = 5'b11010;

  typedef enum logic [2:0] {
    DECODE = 3'd0,
    IMM    = 3'd1,
    INT1   = 3'd2,
    INT2   = 3'd3,
    INT3   = 3'd4
  } state_t;

  // All two-word opcodes share the 101xx prefix
  function automatic logic is_two_word(input logic [OPW-1:0] op);
    return op[OPW-1 -: 3] == 3'b101;
  endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: registered ID/EX bundle from the decode stage to execute.
//   out_valid  - bundle holds a live op
//   opcode     - decoded opcode or injected micro-op
//   op1/op2    - register operands, imm - second instruction word
//   rsrc_addr/rdst_addr - register address fields of the op
interface decode_if
  import decode_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
);
  logic             out_valid;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] imm;
  logic [AW-1:0]    rsrc_addr;
  logic [AW-1:0]    rdst_addr;

  modport master (output out_valid, opcode, op1, op2, imm, rsrc_addr, rdst_addr);
  modport slave  (input  out_valid, opcode, op1, op2, imm, rsrc_addr, rdst_addr);
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass: NREGS x WIDTH register file, synchronous reset to 0,
// synchronous write, two combinational read ports with write-through.
//   clk, rst        - clock, synchronous active-high reset
//   wb_en/addr/data - writeback port
//   ra1/ra2, rd1/rd2 - read addresses and data
module regfile_bypass #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_en,
  input  logic [$clog2(NREGS)-1:0]   wb_addr,
  input  logic [WIDTH-1:0]           wb_data,
  input  logic [$clog2(NREGS)-1:0]   ra1,
  input  logic [$clog2(NREGS)-1:0]   ra2,
  output logic [WIDTH-1:0]           rd1,
  output logic [WIDTH-1:0]           rd2
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];

  // Writeback update
  always_comb begin
    mem_d = mem_q;
    if (wb_en) mem_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  // Write-through so a same-cycle writeback is seen by the reader
  assign rd1 = (wb_en && (wb_addr == ra1)) ? wb_data : mem_q[ra1];
  assign rd2 = (wb_en && (wb_addr == ra2)) ? wb_data : mem_q[ra2];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode between fetch and execute. Splits
// one/two-word instructions, inserts load-use bubbles, kills on flush and
// injects the three interrupt-entry micro-ops.
//   clk, rst                        - clock, synchronous active-high reset
//   instr_valid, instruction        - fetched word
//   load_use, flush_in, interrupt   - hazard, branch kill, interrupt request
//   wb_en, wb_addr, wb_data         - register writeback
//   stall, ack                      - combinational fetch hold / irq accept
//   idex                            - registered ID/EX bundle
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  input  logic [WIDTH-1:0]         instruction,
  input  logic                     load_use,
  input  logic                     flush_in,
  input  logic                     interrupt,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [WIDTH-1:0]         wb_data,
  output logic                     stall,
  output logic                     ack,
  decode_if.master                 idex
);

  localparam int unsigned AW = $clog2(NREGS);

  state_t state_q, state_d;

  logic [OPW-1:0]   op_f;
  logic [AW-1:0]    rs_f, rd_f;
  logic [WIDTH-1:0] rd1, rd2;

  // Partially decoded two-word op waiting for its immediate
  logic [OPW-1:0]   lat_op_q, lat_op_d;
  logic [WIDTH-1:0] lat_op1_q, lat_op1_d, lat_op2_q, lat_op2_d;
  logic [AW-1:0]    lat_rs_q, lat_rs_d, lat_rd_q, lat_rd_d;

  // ID/EX bundle registers
  logic             vld_q, vld_d;
  logic [OPW-1:0]   opc_q, opc_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [AW-1:0]    rs_q, rs_d, rd_q, rd_d;

  assign op_f = instruction[WIDTH-1 -: OPW];
  assign rs_f = instruction[WIDTH-6 -: AW];
  assign rd_f = instruction[WIDTH-9 -: AW];

  regfile_bypass #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .ra1     (rs_f),
    .ra2     (rd_f),
    .rd1     (rd1),
    .rd2     (rd2)
  );

  // Next state, latched op, bundle and combinational stall/ack
  always_comb begin
    state_d   = state_q;
    lat_op_d  = lat_op_q;
    lat_op1_d = lat_op1_q;
    lat_op2_d = lat_op2_q;
    lat_rs_d  = lat_rs_q;
    lat_rd_d  = lat_rd_q;
    vld_d     = 1'b0;
    opc_d     = '0;
    op1_d     = '0;
    op2_d     = '0;
    imm_d     = '0;
    rs_d      = '0;
    rd_d      = '0;
    stall     = 1'b0;
    ack       = 1'b0;

    case (state_q)
      DECODE: begin
        if (flush_in) begin
          state_d = DECODE;
        end else if (load_use) begin
          stall = 1'b1;
        end else if (interrupt) begin
          // The current word is left in fetch until entry completes
          ack     = 1'b1;
          stall   = 1'b1;
          state_d = INT1;
        end else if (instr_valid) begin
          if (is_two_word(op_f)) begin
            lat_op_d  = op_f;
            lat_op1_d = rd1;
            lat_op2_d = rd2;
            lat_rs_d  = rs_f;
            lat_rd_d  = rd_f;
            state_d   = IMM;
          end else begin
            vld_d = 1'b1;
            opc_d = op_f;
            op1_d = rd1;
            op2_d = rd2;
            rs_d  = rs_f;
            rd_d  = rd_f;
          end
        end
      end
      IMM: begin
        if (flush_in) begin
          lat_op_d  = '0;
          lat_op1_d = '0;
          lat_op2_d = '0;
          lat_rs_d  = '0;
          lat_rd_d  = '0;
          state_d   = DECODE;
        end else if (load_use) begin
          stall = 1'b1;
        end else if (instr_valid) begin
          vld_d   = 1'b1;
          opc_d   = lat_op_q;
          op1_d   = lat_op1_q;
          op2_d   = lat_op2_q;
          imm_d   = instruction;
          rs_d    = lat_rs_q;
          rd_d    = lat_rd_q;
          state_d = DECODE;
        end
      end
      INT1: begin
        stall   = 1'b1;
        vld_d   = 1'b1;
        opc_d   = OP_PUSHPCH;
        state_d = INT2;
      end
      INT2: begin
        stall   = 1'b1;
        vld_d   = 1'b1;
        opc_d   = OP_PUSHPCL;
        state_d = INT3;
      end
      INT3: begin
        stall   = 1'b1;
        vld_d   = 1'b1;
        opc_d   = OP_PUSHCCR;
        state_d = DECODE;
      end
      default: state_d = DECODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DECODE;
      lat_op_q  <= '0;
      lat_op1_q <= '0;
      lat_op2_q <= '0;
      lat_rs_q  <= '0;
      lat_rd_q  <= '0;
      vld_q     <= 1'b0;
      opc_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      lat_op_q  <= lat_op_d;
      lat_op1_q <= lat_op1_d;
      lat_op2_q <= lat_op2_d;
      lat_rs_q  <= lat_rs_d;
      lat_rd_q  <= lat_rd_d;
      vld_q     <= vld_d;
      opc_q     <= opc_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rd_q      <= rd_d;
    end
  end

  assign idex.out_valid = vld_q;
  assign idex.opcode    = opc_q;
  assign idex.op1       = op1_q;
  assign idex.op2       = op2_q;
  assign idex.imm       = imm_q;
  assign idex.rsrc_addr = rs_q;
  assign idex.rdst_addr = rd_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed stimulus with a scoreboard queue of expected
// ID/EX bundles; a negedge monitor pops and compares every live op.
module tb_decode_stage;
  import decode_pkg::*;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] imm;
    logic [2:0]  rs;
    logic [2:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT
  logic        rst, instr_valid, load_use, flush_in, interrupt, wb_en;
  logic [15:0] instruction, wb_data;
  logic [2:0]  wb_addr;
  logic        stall, ack;
  decode_if #(.WIDTH(16), .AW(3)) bus ();

  decode_stage #(.WIDTH(16), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .load_use(load_use), .flush_in(flush_in), .interrupt(interrupt),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .ack(ack), .idex(bus)
  );

  // WIDTH=24, NREGS=16 DUT
  logic        rst2, v2, lu2, fl2, irq2, wbe2;
  logic [23:0] ins2, wbd2;
  logic [3:0]  wba2;
  logic        stall2, ack2;
  decode_if #(.WIDTH(24), .AW(4)) bus2 ();

  decode_stage #(.WIDTH(24), .NREGS(16)) dut2 (
    .clk(clk), .rst(rst2), .instr_valid(v2), .instruction(ins2),
    .load_use(lu2), .flush_in(fl2), .interrupt(irq2),
    .wb_en(wbe2), .wb_addr(wba2), .wb_data(wbd2),
    .stall(stall2), .ack(ack2), .idex(bus2)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e, mon_a;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rd);
    return {op, rs, rd, 5'b00000};
  endfunction

  task automatic push(input logic [4:0] op, input logic [15:0] o1, input logic [15:0] o2,
                      input logic [15:0] im, input logic [2:0] rs, input logic [2:0] rd);
    exp_t e;
    e = '{opcode: op, op1: o1, op2: o2, imm: im, rs: rs, rd: rd};
    exp_q.push_back(e);
  endtask

  task automatic push_irq();
    push(OP_PUSHPCH, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
    push(OP_PUSHPCL, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
    push(OP_PUSHCCR, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
  endtask

  task automatic drv(input logic v, input logic [15:0] ins, input logic lu, input logic fl, input logic irq);
    instr_valid = v;
    instruction = ins;
    load_use    = lu;
    flush_in    = fl;
    interrupt   = irq;
  endtask

  task automatic wb(input logic en, input logic [2:0] a, input logic [15:0] d);
    wb_en   = en;
    wb_addr = a;
    wb_data = d;
  endtask

  // One clock of dut: check out_valid, stall, ack mid-cycle, then advance
  task automatic cycle(input logic ev, input logic es, input logic ea, input string nm);
    @(negedge clk);
    chk({nm, ".out_valid"}, 64'(bus.out_valid), 64'(ev));
    chk({nm, ".stall"}, 64'(stall), 64'(es));
    chk({nm, ".ack"}, 64'(ack), 64'(ea));
    @(posedge clk);
    #1;
  endtask

  task automatic cycle2(input logic ev, input logic es, input logic ea, input string nm);
    @(negedge clk);
    chk({nm, ".out_valid"}, 64'(bus2.out_valid), 64'(ev));
    chk({nm, ".stall"}, 64'(stall2), 64'(es));
    chk({nm, ".ack"}, 64'(ack2), 64'(ea));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for dut
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.out_valid) begin
        mon_a = '{opcode: bus.opcode, op1: bus.op1, op2: bus.op2, imm: bus.imm,
                  rs: bus.rsrc_addr, rd: bus.rdst_addr};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_op: got bundle %h, required no live op", mon_a);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_a !== mon_e) begin
            errors++;
            $display("FAIL bundle: got %h, required %h", mon_a, mon_e);
          end
        end
      end else if ({bus.opcode, bus.op1, bus.op2, bus.imm, bus.rsrc_addr, bus.rdst_addr} !== '0) begin
        errors++;
        $display("FAIL idle_fields: got opcode %b op1 %h op2 %h imm %h, required all 0",
                 bus.opcode, bus.op1, bus.op2, bus.imm);
      end
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    wb(1'b0, 3'd0, 16'h0);
    v2 = 1'b0; ins2 = '0; lu2 = 1'b0; fl2 = 1'b0; irq2 = 1'b0;
    wbe2 = 1'b0; wba2 = '0; wbd2 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state of both instances
    @(negedge clk);
    chk("reset_bundle", 64'({bus.out_valid, bus.opcode, bus.op1, bus.op2, bus.imm,
                             bus.rsrc_addr, bus.rdst_addr}), 64'h0);
    chk("reset_stall_ack", 64'({stall, ack}), 64'h0);
    chk("reset24_ctrl", 64'({bus2.out_valid, bus2.opcode, bus2.rsrc_addr, bus2.rdst_addr,
                             stall2, ack2}), 64'h0);
    chk("reset24_data", 64'(bus2.op1 | bus2.op2 | bus2.imm), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Writeback then same-cycle write-through into ADD
    wb(1'b1, 3'd3, 16'h00A5);
    cycle(1'b0, 1'b0, 1'b0, "wb_r3");
    wb(1'b1, 3'd3, 16'h1234);
    drv(1'b1, mk(OP_ADD, 3'd3, 3'd1), 1'b0, 1'b0, 1'b0);
    push(OP_ADD, 16'h1234, 16'h0000, 16'h0, 3'd3, 3'd1);
    cycle(1'b0, 1'b0, 1'b0, "add_issue");
    wb(1'b1, 3'd2, 16'h5A5A);
    drv(1'b1, mk(OP_SUB, 3'd3, 3'd3), 1'b0, 1'b0, 1'b0);
    push(OP_SUB, 16'h1234, 16'h1234, 16'h0, 3'd3, 3'd3);
    cycle(1'b1, 1'b0, 1'b0, "add_out");

    // Two-word LDM
    wb(1'b0, 3'd0, 16'h0);
    drv(1'b1, mk(OP_LDM, 3'd0, 3'd2), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, "sub_out");
    drv(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    push(OP_LDM, 16'h0000, 16'h5A5A, 16'hBEEF, 3'd0, 3'd2);
    cycle(1'b0, 1'b0, 1'b0, "ldm_bubble");
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, "ldm_out");

    // Interrupt entry, request held high during the sequence
    drv(1'b1, mk(OP_ADD, 3'd1, 3'd1), 1'b0, 1'b0, 1'b1);
    push_irq();
    cycle(1'b0, 1'b1, 1'b1, "irq_ack");
    cycle(1'b0, 1'b1, 1'b0, "irq_int1");
    cycle(1'b1, 1'b1, 1'b0, "irq_int2");
    cycle(1'b1, 1'b1, 1'b0, "irq_int3");
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, "irq_done");
    cycle(1'b0, 1'b0, 1'b0, "idle1");

    // Flush in IMM discards IADD; next word decodes as a fresh op
    drv(1'b1, mk(OP_IADD, 3'd3, 3'd2), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, "iadd_w1");
    drv(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, "iadd_flush");
    drv(1'b1, mk(OP_ADD, 3'd2, 3'd3), 1'b0, 1'b0, 1'b0);
    push(OP_ADD, 16'h5A5A, 16'h1234, 16'h0, 3'd2, 3'd3);
    cycle(1'b0, 1'b0, 1'b0, "post_flush");
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, "post_flush_out");

    // Flush during INT2 is ignored
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    push_irq();
    cycle(1'b0, 1'b1, 1'b1, "irq2_ack");
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, "irq2_int1");
    drv(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, "irq2_int2_flush");
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, "irq2_int3");
    cycle(1'b1, 1'b0, 1'b0, "irq2_done");
    cycle(1'b0, 1'b0, 1'b0, "idle2");

    // load_use beats interrupt; ack the cycle after it drops
    drv(1'b1, mk(OP_ADD, 3'd1, 3'd1), 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, "lu_irq");
    drv(1'b1, mk(OP_ADD, 3'd1, 3'd1), 1'b0, 1'b0, 1'b1);
    push_irq();
    cycle(1'b0, 1'b1, 1'b1, "irq3_ack");
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, "irq3_int1");
    cycle(1'b1, 1'b1, 1'b0, "irq3_int2");
    cycle(1'b1, 1'b1, 1'b0, "irq3_int3");
    cycle(1'b1, 1'b0, 1'b0, "irq3_done");

    // load_use holds IMM; interrupt not taken in IMM
    drv(1'b1, mk(OP_LDD, 3'd1, 3'd3), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, "ldd_w1");
    drv(1'b1, 16'h2222, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, "ldd_lu");
    drv(1'b1, 16'h3333, 1'b0, 1'b0, 1'b1);
    push(OP_LDD, 16'h0000, 16'h1234, 16'h3333, 3'd1, 3'd3);
    cycle(1'b0, 1'b0, 1'b0, "ldd_w2_irq");
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, "ldd_out");
    cycle(1'b0, 1'b0, 1'b0, "idle3");

    // WIDTH=24 / NREGS=16: R15 round trip, then reset mid-INT2
    rst2 = 1'b0;
    wbe2 = 1'b1; wba2 = 4'd15; wbd2 = 24'hABCDEF;
    cycle2(1'b0, 1'b0, 1'b0, "w24_wb");
    wbe2 = 1'b0;
    v2 = 1'b1; ins2 = 24'h0F8000;
    cycle2(1'b0, 1'b0, 1'b0, "w24_issue");
    v2 = 1'b0; ins2 = '0;
    @(negedge clk);
    chk("w24_ctrl", 64'({bus2.out_valid, bus2.opcode, bus2.rsrc_addr, bus2.rdst_addr}),
        64'({1'b1, OP_ADD, 4'd15, 4'd8}));
    chk("w24_op1", 64'(bus2.op1), 64'h00ABCDEF);
    chk("w24_op2_imm", 64'({bus2.op2, bus2.imm}), 64'h0);
    @(posedge clk);
    #1;
    irq2 = 1'b1;
    cycle2(1'b0, 1'b1, 1'b1, "w24_ack");
    irq2 = 1'b0;
    cycle2(1'b0, 1'b1, 1'b0, "w24_int1");
    rst2 = 1'b1;
    cycle2(1'b1, 1'b1, 1'b0, "w24_int2_rst");
    @(negedge clk);
    chk("w24_rst_ctrl", 64'({bus2.out_valid, bus2.opcode, bus2.rsrc_addr, bus2.rdst_addr,
                             stall2, ack2}), 64'h0);
    chk("w24_rst_data", 64'(bus2.op1 | bus2.op2 | bus2.imm), 64'h0);
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    cycle2(1'b0, 1'b0, 1'b0, "w24_after_rst");

    cycle(1'b0, 1'b0, 1'b0, "tail");
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
